cond_issue_ctrl: RTL

Issue-stage controller that owns the architectural CPSR flags and sequences conditional instructions from decode into execute. It holds one instruction at a time. It stalls conditional instructions while flag-setting instructions are still in flight. Once the hazard clears, it evaluates the 4-bit condition code and issues the instruction as either execute or squash. It sits between the decoder and the EX stage and provides single-entry buffering with a ready/valid handshake on both sides.

---
 rtl/cond_issue_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cond_issue_ctrl.sv
// Issue-stage controller: owns the CPSR flags, stalls conditional instructions
// behind in-flight flag writers, then issues each held instruction as execute or squash.
module cond_issue_ctrl #(
  parameter int MAX_PEND = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic [3:0] dec_cond,
  input  logic       dec_setflags,
  output logic       iss_valid,
  input  logic       iss_ready,
  output logic       iss_exec,
  output logic       iss_setflags,
  input  logic       flag_wr_valid,
  input  logic [3:0] flag_wr_data,
  output logic [3:0] cpsr,
  output logic [2:0] pend_cnt,
  output logic       proto_err
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid/payload hold steady until that transfer.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  localparam logic [2:0] MAX_PEND_L = 3'(MAX_PEND);

  state_e     state_q, state_d;
  logic [3:0] cond_q, cond_d;
  logic       setflags_q, setflags_d;
  logic       iss_exec_q, iss_exec_d;
  logic       iss_setflags_q, iss_setflags_d;
  logic [3:0] cpsr_q, cpsr_d;
  logic [2:0] pend_q, pend_d;
  logic       proto_err_q, proto_err_d;

  logic       handshake;
  logic       pend_inc;
  logic       dec_ready_c;
  logic       accept;
  logic       load;
  logic [3:0] cand_cond;
  logic       cand_sf;
  logic       hazard;
  logic       pass;

  // Flags: [0] Z, [1] C, [2] N, [3] V. Class 111 is always-true.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic r;
    r = 1'b0;
    case (cond[3:1])
      3'b000:  r = f[0];
      3'b001:  r = f[1];
      3'b010:  r = f[2];
      3'b011:  r = f[3];
      3'b100:  r = f[1] & ~f[0];
      3'b101:  r = ~(f[2] ^ f[3]);
      3'b110:  r = ~f[0] & ~(f[2] ^ f[3]);
      default: r = 1'b1;
    endcase
    if (cond[3:1] != 3'b111) r = r ^ cond[0];
    return r;
  endfunction

  always_comb begin
    handshake   = (state_q == ST_ISSUE) && iss_ready;
    pend_inc    = handshake && iss_setflags_q;
    pend_d      = pend_q;
    proto_err_d = proto_err_q;
    if (pend_inc && !flag_wr_valid) begin
      pend_d = pend_q + 3'd1;
    end else if (!pend_inc && flag_wr_valid) begin
      // A writeback nobody asked for leaves the counter at zero and flags it.
      if (pend_q == 3'd0) proto_err_d = 1'b1;
      else                pend_d      = pend_q - 3'd1;
    end
    cpsr_d = flag_wr_valid ? flag_wr_data : cpsr_q;

    dec_ready_c = rst_n && !flush && ((state_q == ST_EMPTY) || handshake);
    accept      = dec_ready_c && dec_valid;
    cand_cond   = accept ? dec_cond : cond_q;
    cand_sf     = accept ? dec_setflags : setflags_q;
    hazard      = ((cand_cond[3:1] != 3'b111) && ((pend_d != 3'd0) || flag_wr_valid)) ||
                  (cand_sf && (pend_d == MAX_PEND_L));
    pass        = cond_pass(cand_cond, cpsr_q);
    load        = accept || ((state_q == ST_WAIT) && !flush);

    state_d        = state_q;
    cond_d         = cond_q;
    setflags_d     = setflags_q;
    iss_exec_d     = iss_exec_q;
    iss_setflags_d = iss_setflags_q;
    if (load) begin
      cond_d         = cand_cond;
      setflags_d     = cand_sf;
      state_d        = hazard ? ST_WAIT : ST_ISSUE;
      iss_exec_d     = !hazard && pass;
      iss_setflags_d = !hazard && pass && cand_sf;
    end else if (((state_q == ST_ISSUE) && (handshake || flush)) ||
                 ((state_q == ST_WAIT) && flush)) begin
      state_d        = ST_EMPTY;
      iss_exec_d     = 1'b0;
      iss_setflags_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EMPTY;
      cond_q         <= 4'd0;
      setflags_q     <= 1'b0;
      iss_exec_q     <= 1'b0;
      iss_setflags_q <= 1'b0;
      cpsr_q         <= 4'd0;
      pend_q         <= 3'd0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cond_q         <= cond_d;
      setflags_q     <= setflags_d;
      iss_exec_q     <= iss_exec_d;
      iss_setflags_q <= iss_setflags_d;
      cpsr_q         <= cpsr_d;
      pend_q         <= pend_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign dec_ready    = dec_ready_c;
  assign iss_valid    = (state_q == ST_ISSUE);
  assign iss_exec     = iss_exec_q;
  assign iss_setflags = iss_setflags_q;
  assign cpsr         = cpsr_q;
  assign pend_cnt     = pend_q;
  assign proto_err    = proto_err_q;

endmodule
